// File: rtl/processor_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, ALU codes, FSM states
// and instruction field positions. Used by the controller, the ALU and benches.
package processor_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RX_MSB  = 12;
    localparam int RX_LSB  = 10;
    localparam int RY_MSB  = 9;
    localparam int RY_LSB  = 7;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IMM   = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4
    } state_t;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        return (op != OP_MV) && (op != OP_MVI) && !is_alu(op);
    endfunction

    function automatic logic [1:0] alu_of(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/processor_control_decode.sv
// Combinational map from {state, instruction fields} to the datapath mux
// selects and the register/ALU enables.
module processor_control_decode
    import processor_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  state_t           state,
    input  logic [2:0]       op,
    input  logic [2:0]       rx,
    input  logic [2:0]       ry,
    output logic             inReady,
    output logic [2:0]       regSelect,
    output logic             regRSelect,
    output logic             immSelect,
    output logic [NREGS-1:0] regWrite,
    output logic             aLoad,
    output logic             rLoad,
    output logic [1:0]       aluOp,
    output logic             done
);

    always_comb begin
        inReady    = 1'b0;
        regSelect  = 3'd0;
        regRSelect = 1'b0;
        immSelect  = 1'b0;
        regWrite   = '0;
        aLoad      = 1'b0;
        rLoad      = 1'b0;
        aluOp      = ALU_ADD;
        done       = 1'b0;
        case (state)
            S_FETCH, S_IMM: inReady = 1'b1;
            S_T1: begin
                if (op == OP_MV) begin
                    regSelect    = ry;
                    regWrite[rx] = 1'b1;
                    done         = 1'b1;
                end else if (is_alu(op)) begin
                    regSelect = rx;
                    aLoad     = 1'b1;
                end else begin
                    // illegal opcode completes as a done-only no-op
                    done = 1'b1;
                end
            end
            S_T2: begin
                if (op == OP_MVI) begin
                    immSelect    = 1'b1;
                    regWrite[rx] = 1'b1;
                    done         = 1'b1;
                end else begin
                    regSelect = ry;
                    rLoad     = 1'b1;
                    aluOp     = alu_of(op);
                end
            end
            S_T3: begin
                regRSelect   = 1'b1;
                regWrite[rx] = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/processor_control.sv
// Multi-cycle control FSM for the 16-bit processor.
// Optional sticky illegalOp flag enabled by PROCESSOR_CONTROL_ILLEGAL_OP_EN.
//
//   state   | meaning
//   FETCH   | wait for and latch an instruction word
//   IMM     | mvi: wait for and latch the immediate word
//   T1      | mv/illegal: finish; alu ops: load A from rx
//   T2      | mvi: write imm to rx; alu ops: run ALU on ry into R
//   T3      | alu ops: write R to rx
module processor_control
    import processor_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    output logic              inReady,
    output logic [2:0]        regSelect,
    output logic              regRSelect,
    output logic              immSelect,
    output logic [DATA_W-1:0] imm,
    output logic [NREGS-1:0]  regWrite,
    output logic              aLoad,
    output logic              rLoad,
    output logic [1:0]        aluOp,
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
    output logic              illegalOp,
`endif
    output logic              done
);

    state_t     state;
    // only the opcode and register fields of IR are ever decoded
    logic [2:0] ir_op;
    logic [2:0] ir_rx;
    logic [2:0] ir_ry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ir_op <= 3'd0;
            ir_rx <= 3'd0;
            ir_ry <= 3'd0;
            imm   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (inValid) begin
                        ir_op <= inData[OPC_MSB:OPC_LSB];
                        ir_rx <= inData[RX_MSB:RX_LSB];
                        ir_ry <= inData[RY_MSB:RY_LSB];
                        state <= (inData[OPC_MSB:OPC_LSB] == OP_MVI) ? S_IMM : S_T1;
                    end
                end
                S_IMM: begin
                    if (inValid) begin
                        imm   <= inData;
                        state <= S_T2;
                    end
                end
                S_T1:    state <= is_alu(ir_op) ? S_T2 : S_FETCH;
                S_T2:    state <= (ir_op == OP_MVI) ? S_FETCH : S_T3;
                S_T3:    state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            illegalOp <= 1'b0;
        else if (state == S_T1 && is_illegal(ir_op))
            illegalOp <= 1'b1;
    end
`endif

    processor_control_decode #(
        .NREGS (NREGS)
    ) u_decode (
        .state      (state),
        .op         (ir_op),
        .rx         (ir_rx),
        .ry         (ir_ry),
        .inReady    (inReady),
        .regSelect  (regSelect),
        .regRSelect (regRSelect),
        .immSelect  (immSelect),
        .regWrite   (regWrite),
        .aLoad      (aLoad),
        .rLoad      (rLoad),
        .aluOp      (aluOp),
        .done       (done)
    );

endmodule

// File: tb/tb_processor_control.sv
// Directed self-checking bench for processor_control.
// Builds with or without PROCESSOR_CONTROL_ILLEGAL_OP_EN.
module tb_processor_control;
    import processor_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] inData;
    logic        inValid;
    logic        inReady;
    logic [2:0]  regSelect;
    logic        regRSelect;
    logic        immSelect;
    logic [15:0] imm;
    logic [7:0]  regWrite;
    logic        aLoad;
    logic        rLoad;
    logic [1:0]  aluOp;
    logic        done;
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
    logic        illegalOp;
`endif

    int checks;
    int failures;

    processor_control dut (
        .clock      (clock),
        .reset      (reset),
        .inData     (inData),
        .inValid    (inValid),
        .inReady    (inReady),
        .regSelect  (regSelect),
        .regRSelect (regRSelect),
        .immSelect  (immSelect),
        .imm        (imm),
        .regWrite   (regWrite),
        .aLoad      (aLoad),
        .rLoad      (rLoad),
        .aluOp      (aluOp),
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
        .illegalOp  (illegalOp),
`endif
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {inReady, regSelect, regRSelect, immSelect, regWrite, aLoad, rLoad, aluOp, done}
    function automatic logic [31:0] ov(input logic rdy, input logic [2:0] sel, input logic rsel,
                                       input logic isel, input logic [7:0] wr, input logic al,
                                       input logic rl, input logic [1:0] op, input logic dn);
        return {13'd0, rdy, sel, rsel, isel, wr, al, rl, op, dn};
    endfunction

    function automatic logic [31:0] outs();
        return {13'd0, inReady, regSelect, regRSelect, immSelect, regWrite, aLoad, rLoad, aluOp, done};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        inValid  = 1'b0;
        inData   = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        chk("reset_outs", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        chk("reset_imm", 32'(imm), 32'h0);

        // mv r3,r5
        inData = 16'h0E80; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("mv_t1", outs(), ov(0, 3'd5, 0, 0, 8'b0000_1000, 0, 0, 2'b00, 1));
        tick();
        chk("mv_fetch", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));

        // mvi r2, 42 with a 3-cycle stall in IMM
        inData = 16'h2800; inValid = 1'b1;
        tick();
        inValid = 1'b0; inData = 16'hFFFF;
        chk("mvi_imm0", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        tick();
        chk("mvi_imm1", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        tick();
        chk("mvi_imm2", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        chk("mvi_imm_not_taken", 32'(imm), 32'h0);
        inData = 16'd42; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("mvi_t2", outs(), ov(0, 0, 0, 1, 8'b0000_0100, 0, 0, 2'b00, 1));
        chk("mvi_imm_val", 32'(imm), 32'd42);
        tick();
        chk("mvi_fetch", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));

        // sub r6,r1
        inData = 16'h7880; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("sub_t1", outs(), ov(0, 3'd6, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        tick();
        chk("sub_t2", outs(), ov(0, 3'd1, 0, 0, 8'h00, 0, 1, 2'b01, 0));
        tick();
        chk("sub_t3", outs(), ov(0, 0, 1, 0, 8'b0100_0000, 0, 0, 2'b00, 1));
        chk("sub_imm_kept", 32'(imm), 32'd42);
        tick();

        // and r7,r7 (rx==ry)
        inData = 16'h9F80; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("and_t1", outs(), ov(0, 3'd7, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        tick();
        chk("and_t2", outs(), ov(0, 3'd7, 0, 0, 8'h00, 0, 1, 2'b10, 0));
        tick();
        chk("and_t3", outs(), ov(0, 0, 1, 0, 8'b1000_0000, 0, 0, 2'b00, 1));
        tick();

        // back-to-back add r1,r2 then mv r4,r0 with inValid held high
        inData = 16'h4500; inValid = 1'b1;
        tick();
        chk("b2b_add_t1", outs(), ov(0, 3'd1, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        tick();
        chk("b2b_add_t2", outs(), ov(0, 3'd2, 0, 0, 8'h00, 0, 1, 2'b00, 0));
        tick();
        chk("b2b_add_t3", outs(), ov(0, 0, 1, 0, 8'b0000_0010, 0, 0, 2'b00, 1));
        inData = 16'h1000;
        tick();
        chk("b2b_fetch", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        tick();
        inValid = 1'b0;
        chk("b2b_mv_t1", outs(), ov(0, 3'd0, 0, 0, 8'b0001_0000, 0, 0, 2'b00, 1));
        tick();

        // illegal opcode 111
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
        chk("illegal_flag_pre", 32'(illegalOp), 32'd0);
`endif
        inData = 16'hE000; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("illegal_t1", outs(), ov(0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 1));
        tick();
        chk("illegal_fetch", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
        chk("illegal_flag_set", 32'(illegalOp), 32'd1);
`endif
        inData = 16'h0E80; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("post_illegal_mv", outs(), ov(0, 3'd5, 0, 0, 8'b0000_1000, 0, 0, 2'b00, 1));
        tick();
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
        chk("illegal_flag_sticky", 32'(illegalOp), 32'd1);
`endif

        // reset in T2 of add r1,r2 aborts at once
        inData = 16'h4500; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        chk("abort_t2", outs(), ov(0, 3'd2, 0, 0, 8'h00, 0, 1, 2'b00, 0));
        #1 reset = 1'b1;
        #1;
        chk("abort_async", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        chk("abort_imm", 32'(imm), 32'h0);
`ifdef PROCESSOR_CONTROL_ILLEGAL_OP_EN
        chk("abort_flag", 32'(illegalOp), 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick();
        chk("abort_no_write", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));
        tick();
        chk("abort_idle", outs(), ov(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processor_control.md
Name: processor_control

Overview:
- Multi-cycle control FSM for the 16-bit processor.
- Sits directly upstream of the datapath operand mux and drives its three select inputs: regSelect, regRSelect and immSelect.
- Accepts instruction and immediate words over a valid/ready handshake.
- Sequences register-file writes, accumulator-A and result-register loads, and the ALU operation.
- Holds the immediate word that the mux forwards as imm.

Parameters:
- DATA_W, 16, width of instruction/immediate words and the imm output.
- NREGS, 8, number of general registers; fixes the regWrite width and the 3-bit register fields.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inData  in  16  instruction word, or immediate word during mvi.
- inValid  in  1  inData valid.
- inReady  out  1  controller accepts inData this cycle.
- regSelect  out  3  mux register select.
- regRSelect  out  1  mux selects the result register R.
- immSelect  out  1  mux selects imm.
- imm  out  16  captured immediate.
- regWrite  out  8  one-hot register write enable.
- aLoad  out  1  load accumulator A from the mux output.
- rLoad  out  1  load R from the ALU output.
- aluOp  out  2  ALU operation: 00 add, 01 sub, 10 and.
- done  out  1  single-cycle pulse in the final cycle of each instruction.

Behaviour:
- Instruction format:
  - opcode = inData[15:13]
  - rx = inData[12:10]
  - ry = inData[9:7]
  - inData[6:0] are ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and; 101–111 are illegal.
- States: FETCH, IMM, T1, T2, T3.
- All outputs except imm are combinational decodes of the state and the instruction register (IR). Outputs not listed for a state are 0.
- Reset (async): state=FETCH, IR=0, imm=0. All outputs 0 except inReady=1.
- FETCH:
  - inReady=1.
  - When inValid=1: IR<=inData; go to IMM if the opcode is mvi, else T1.
  - When inValid=0: hold.
- IMM:
  - inReady=1; wait for inValid.
  - On inValid=1: imm<=inData; go to T2.
- mv (T1): regSelect=ry, regWrite[rx]=1, done=1; go to FETCH. Two cycles from acceptance to done.
- mvi (T2): immSelect=1, regWrite[rx]=1, done=1; go to FETCH.
- add/sub/and:
  - T1: regSelect=rx, aLoad=1.
  - T2: regSelect=ry, rLoad=1, aluOp per opcode.
  - T3: regRSelect=1, regWrite[rx]=1, done=1; go to FETCH.
- Illegal opcode: T1 asserts done=1 only, with no writes or loads; go to FETCH.
- Exactly one of regSelect use, immSelect or regRSelect is meaningful per cycle. immSelect and regRSelect are never asserted together.
- rx==ry is legal:
  - mv is a no-op write.
  - sub yields 0.
- inReady=0 in T1/T2/T3. inData is ignored there, and inValid may stay high without effect.
- Back-to-back: the next instruction is accepted in the FETCH cycle directly after done.
- Reset asserted mid-instruction aborts immediately: no partial write completes and no done is issued.
- imm holds its value until the next mvi; it is not cleared by other instructions.

Optional Feature:
- Macro: PROCESSOR_CONTROL_ILLEGAL_OP_EN.
- Defined:
  - Adds output illegalOp (1 bit), a sticky flag set in T1 of an illegal opcode.
  - Cleared only by reset.
  - The illegal instruction still completes as a done-only no-op.
- Undefined: the port is absent and illegal opcodes are silent no-ops.

Decomposition:
- Shared package (processor_pkg):
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND
  - ALU op codes ALU_ADD, ALU_SUB, ALU_AND
  - state encoding constants
  - field position constants for opcode, rx and ry.
  - The ALU and the testbench also use this package.
- One sub-module, processor_control_decode: combinational map from {state, IR} to all select/enable outputs. The FSM registers stay in processor_control.

Test Plan:
- Reset while in T2 of an add: outputs return immediately to reset values (inReady=1, others 0); no regWrite pulse follows.
- mv r3,r5 (inData=16'h0E80) accepted → next cycle regSelect=5, regWrite=8'b0000_1000, done=1; following cycle inReady=1.
- mvi r2, then immediate 16'd42:
  - instruction 16'h2800 accepted.
  - IMM held 3 cycles with inValid=0 (inReady=1 throughout).
  - 42 accepted → imm=42, immSelect=1, regWrite=8'b0000_0100, done=1.
- sub r6,r1 (inData=16'h7880):
  - T1: regSelect=6, aLoad=1.
  - T2: regSelect=1, rLoad=1, aluOp=01.
  - T3: regRSelect=1, regWrite=8'b0100_0000, done=1.
- Back-to-back add then mv with inValid held high: second instruction accepted in the FETCH cycle right after the first done; inReady=0 in T1–T3.
- Opcode 111 (inData=16'hE000):
  - done only, no writes.
  - With PROCESSOR_CONTROL_ILLEGAL_OP_EN, illegalOp=1 and stays 1 across later legal instructions until reset.
